// File: rtl/vga_pkg.sv
// Constants and state encoding shared by the VGA frame-buffer blocks
// (pixel reader and the processor-side transfer block).
package vga_pkg;
  localparam int unsigned WORD_COUNT_DEF = 19200;
  localparam int unsigned PIXEL_W        = 8;
  localparam int unsigned PIX_PER_WORD   = 4;
  localparam int unsigned WORD_W         = PIXEL_W * PIX_PER_WORD;
  localparam int unsigned IDX_W          = $clog2(PIX_PER_WORD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/word_unpacker.sv
// Two-slot word buffer (cur/nxt) that serialises 32-bit words into a byte stream
// under a valid/ready handshake, least-significant byte first.
module word_unpacker
  import vga_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [WORD_W-1:0]  word_i,
  input  logic               word_valid_i,
  input  logic               pixel_ready_i,
  output logic [PIXEL_W-1:0] pixel_o,
  output logic               pixel_valid_o,
  output logic               word_done_o,
  output logic [1:0]         fill_o
);
  logic [WORD_W-1:0]  cur_q, cur_d;
  logic [WORD_W-1:0]  nxt_q, nxt_d;
  logic               cur_valid_q, cur_valid_d;
  logic               nxt_valid_q, nxt_valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PIXEL_W-1:0] bytes_w [PIX_PER_WORD];
  logic               xfer_w;

  for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_byte
    assign bytes_w[gi] = cur_q[gi*PIXEL_W +: PIXEL_W];
  end

  assign pixel_o       = bytes_w[idx_q];
  assign pixel_valid_o = cur_valid_q;
  assign xfer_w        = cur_valid_q & pixel_ready_i;
  assign word_done_o   = xfer_w & (idx_q == IDX_LAST);
  assign fill_o        = {1'b0, cur_valid_q} + {1'b0, nxt_valid_q};

  always_comb begin
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    cur_valid_d = cur_valid_q;
    nxt_valid_d = nxt_valid_q;
    idx_d       = idx_q;
    if (xfer_w) begin
      idx_d = idx_q + IDX_W'(1);
    end
    // A returning word lands in cur whenever cur is empty or being vacated.
    if (word_done_o) begin
      idx_d = '0;
      if (nxt_valid_q) begin
        cur_d       = nxt_q;
        nxt_valid_d = 1'b0;
        if (word_valid_i) begin
          nxt_d       = word_i;
          nxt_valid_d = 1'b1;
        end
      end else if (word_valid_i) begin
        cur_d = word_i;
      end else begin
        cur_valid_d = 1'b0;
      end
    end else if (word_valid_i) begin
      if (!cur_valid_q) begin
        cur_d       = word_i;
        cur_valid_d = 1'b1;
      end else begin
        nxt_d       = word_i;
        nxt_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cur_q       <= '0;
      nxt_q       <= '0;
      cur_valid_q <= 1'b0;
      nxt_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      cur_valid_q <= cur_valid_d;
      nxt_valid_q <= nxt_valid_d;
      idx_q       <= idx_d;
    end
  end
endmodule

// File: rtl/framebuffer_pixel_reader.sv
// Frame-memory scan-out reader: sequential word prefetch feeding a byte unpacker.
// Define CONTINUOUS_FRAME_EN for free-running frames (address wrap, no DONE state).
module framebuffer_pixel_reader
  import vga_pkg::*;
#(
  parameter int unsigned WORD_COUNT = WORD_COUNT_DEF,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic [ADDR_W-1:0]  mem_address_o,
  output logic               mem_rd_o,
  input  logic [WORD_W-1:0]  mem_data_i,
  output logic [PIXEL_W-1:0] pixel_o,
  output logic               pixel_valid_o,
  input  logic               pixel_ready_i,
  output logic               busy_o,
  output logic               frame_done_o
);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORD_COUNT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic              inflight_q;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [1:0]        fill_w, occupancy_w;
  logic              word_done_w, last_xfer_w, fetch_ok_w;

  word_unpacker u_unpacker (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .word_i        (mem_data_i),
    .word_valid_i  (inflight_q),
    .pixel_ready_i (pixel_ready_i),
    .pixel_o       (pixel_o),
    .pixel_valid_o (pixel_valid_o),
    .word_done_o   (word_done_w),
    .fill_o        (fill_w)
  );

  assign occupancy_w = fill_w + {1'b0, inflight_q};

`ifdef CONTINUOUS_FRAME_EN
  assign fetch_ok_w = 1'b1;
`else
  assign fetch_ok_w = (fetch_addr_q <= LAST_WORD);
`endif

  assign mem_rd_o      = (state_q == RUN) && (occupancy_w < 2'd2) && fetch_ok_w;
  assign mem_address_o = fetch_addr_q;
  assign last_xfer_w   = word_done_w && (words_q == LAST_WORD);
  assign busy_o        = busy_q;
  assign frame_done_o  = frame_done_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    words_d      = words_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = RUN;
          fetch_addr_d = '0;
          words_d      = '0;
        end
      end
      RUN: begin
        if (mem_rd_o) begin
`ifdef CONTINUOUS_FRAME_EN
          fetch_addr_d = (fetch_addr_q == LAST_WORD) ? '0 : fetch_addr_q + ADDR_W'(1);
`else
          fetch_addr_d = fetch_addr_q + ADDR_W'(1);
`endif
        end
        // words_q counts fully consumed words so the last byte of the frame is known.
        if (word_done_w) begin
          words_d = last_xfer_w ? '0 : words_q + ADDR_W'(1);
        end
`ifndef CONTINUOUS_FRAME_EN
        if (last_xfer_w) begin
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d       = (state_d == RUN);
  assign frame_done_d = last_xfer_w;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      words_q      <= '0;
      inflight_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      words_q      <= words_d;
      inflight_q   <= mem_rd_o;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_framebuffer_pixel_reader.sv
// Randomised self-checking bench for framebuffer_pixel_reader against a byte-stream model.
// Build with CONTINUOUS_FRAME_EN defined to exercise the free-running frame mode.
`timescale 1ns/1ps
module tb_framebuffer_pixel_reader;
`ifdef CONTINUOUS_FRAME_EN
  localparam int WC = 2;
`else
  localparam int WC = 4;
`endif
  localparam int AW  = 17;
  localparam int PPF = 4 * WC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] addr;
  logic          rd;
  logic [31:0]   mem_data = '0;
  logic [7:0]    pixel;
  logic          pv, busy, fdone;

  int n_checks = 0;
  int n_errors = 0;

  framebuffer_pixel_reader #(.WORD_COUNT(WC), .ADDR_W(AW)) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .start_i       (start),
    .mem_address_o (addr),
    .mem_rd_o      (rd),
    .mem_data_i    (mem_data),
    .pixel_o       (pixel),
    .pixel_valid_o (pv),
    .pixel_ready_i (ready),
    .busy_o        (busy),
    .frame_done_o  (fdone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Frame memory contents: word n holds pixels n0,n1,n2,n3 (low byte first).
  function automatic logic [31:0] word_of(input int n);
    logic [7:0] b;
    b = 8'(n << 4);
    return {b, b, b, b} + 32'h03020100;
  endfunction

  // One-cycle read latency memory; garbage on the bus when no read was issued.
  logic          rd_s = 1'b0;
  logic [AW-1:0] addr_s = '0;
  always @(negedge clk) begin
    rd_s   = rd;
    addr_s = addr;
  end
  always @(posedge clk) mem_data <= rd_s ? word_of(int'(addr_s)) : $urandom;

  // Reference model: the stream is pixel j = 16*(word j/4 mod WC) + j%4.
  int         cyc = 0, n_rd = 0, n_xfer = 0, fx = 0, last_xfer_cyc = -10;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_pix = '0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      n_rd = 0; n_xfer = 0; fx = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(pv), 1);
        check("hold_pixel", 32'(pixel), 32'(prev_pix));
      end
      if (rd) begin
        check("occupancy_lt2", 32'((n_rd - n_xfer / 4) < 2), 1);
        check("rd_address", 32'(addr), 32'(n_rd % WC));
`ifndef CONTINUOUS_FRAME_EN
        check("rd_in_frame", 32'(n_rd < WC), 1);
`endif
        n_rd++;
      end
      if (fdone) begin
        check("frame_pixels", 32'(fx), PPF);
        check("done_after_last", 32'(cyc), 32'(last_xfer_cyc + 1));
        fx = 0;
`ifdef CONTINUOUS_FRAME_EN
        check("busy_at_done", 32'(busy), 1);
`else
        check("frame_reads", 32'(n_rd), WC);
        check("busy_at_done", 32'(busy), 0);
        check("buffers_empty", 32'(pv), 0);
        n_rd = 0; n_xfer = 0;
`endif
      end
      if (pv && ready) begin
        check("pixel", 32'(pixel), 32'(((n_xfer / 4) % WC) * 16 + n_xfer % 4));
`ifndef CONTINUOUS_FRAME_EN
        check("xfer_in_frame", 32'(fx < PPF), 1);
`endif
        n_xfer++; fx++; last_xfer_cyc = cyc;
      end
      prev_stall = pv && !ready;
      prev_pix   = pixel;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start from IDLE and check the start-up latency; returns in cycle k+3.
  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_k1", 32'(busy), 1);
    check("rd_k1", 32'(rd), 1);
    check("addr_k1", 32'(addr), 0);
    tick();
    check("valid_k2", 32'(pv), 0);
    tick();
    check("valid_k3", 32'(pv), 1);
    check("pixel_k3", 32'(pixel), 0);
  endtask

  // mode 0: ready=1, 1: ready 1,0,0,..., 2: 10-cycle stall on word 1 byte 3, 3: random + stray starts
  task automatic run_frame(input int mode);
    int  stall = 0;
    bit  stalled = 1'b0;
    bit  seen = 1'b0;
    int  done_at = -1;
    ready = 1'b1;
    start_frame();
    for (int i = 0; i < 400; i++) begin
      case (mode)
        0: ready = 1'b1;
        1: ready = (i % 3 == 0);
        2: begin
          if (stall == 0 && !stalled && n_xfer == 7) begin
            stall = 10; stalled = 1'b1;
          end
          ready = (stall == 0);
          if (stall > 0) begin
            if (stall <= 7) check("stall_no_rd", 32'(rd), 0);
            stall--;
          end
        end
        default: begin
          ready = 1'($urandom % 2);
          start = (n_xfer > 2 && n_xfer < PPF - 6) && ($urandom_range(0, 3) == 0);
        end
      endcase
      tick();
      if (fdone) begin
        seen = 1'b1; done_at = i;
        break;
      end
    end
    start = 1'b0;
    ready = 1'b1;
    check("frame_done_seen", 32'(seen), 1);
    if (mode == 0) check("frame_cycles", 32'(done_at), PPF - 1);
    $display("frame mode %0d: done_at=%0d", mode, done_at);
    tick();
    check("done_pulse_len", 32'(fdone), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic run_cont(input int nframes);
    int last = -1;
    int cnt = 0;
    ready = 1'b1;
    start_frame();
    for (int i = 0; i < nframes * PPF + 50 && cnt < nframes; i++) begin
      start = (i == 3);
      tick();
      check("busy_cont_run", 32'(busy), 1);
      if (fdone) begin
        if (cnt == 0) check("first_done", 32'(i), PPF - 1);
        else          check("done_period", 32'(i - last), PPF);
        last = i; cnt++;
      end
    end
    start = 1'b0;
    check("cont_frames", 32'(cnt), 32'(nframes));
    $display("continuous run: %0d frame_done pulses", cnt);
  endtask

  task automatic reset_mid_frame();
    bit hit = 1'b0;
    ready = 1'b1;
    start_frame();
    for (int i = 0; i < 100; i++) begin
      if (rd && n_xfer >= 4) begin
        hit = 1'b1;
        break;
      end
      ready = 1'($urandom % 2);
      tick();
    end
    check("midframe_rd_found", 32'(hit), 1);
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("rst_rd", 32'(rd), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_pixel", 32'(pixel), 0);
    check("rst_valid", 32'(pv), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(fdone), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    check("stale_ignored", 32'(pv), 0);
    tick();
    check("stale_ignored2", 32'(pv), 0);
    $display("mid-frame reset applied");
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd", 32'(rd), 0);
    check("reset_addr", 32'(addr), 0);
    check("reset_pixel", 32'(pixel), 0);
    check("reset_valid", 32'(pv), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(fdone), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    check("idle_no_rd", 32'(rd), 0);
    check("idle_not_busy", 32'(busy), 0);
`ifdef CONTINUOUS_FRAME_EN
    run_cont(4);
    reset_mid_frame();
    run_cont(3);
`else
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(3);
    reset_mid_frame();
    run_frame(0);
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/framebuffer_pixel_reader.md
# framebuffer_pixel_reader

Reads 32-bit words from the VGA frame memory and unpacks each word into four 8-bit pixels for the display scan-out path. It sits on the read port of the frame memory that the processor-side transfer block fills. It generates sequential word addresses and prefetches one word ahead, so it can deliver one pixel per clock under a valid/ready handshake.

## Interface
- WORD_COUNT, 19200: words per frame (320x240 pixels, 8 bpp, 4 pixels/word).
- ADDR_W, 17: width of the memory address.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle frame start request; sampled only in IDLE.
- mem_address  out  ADDR_W  word address presented to frame memory.
- mem_rd  out  1  read strobe; memory returns data exactly 1 cycle later.
- mem_data  in  32  read data, valid the cycle after mem_rd.
- pixel  out  8  current pixel byte.
- pixel_valid  out  1  pixel holds valid data.
- pixel_ready  in  1  consumer accepts pixel this cycle.
- busy  out  1  high in RUN.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame transfers.

## Operation
- Reset sets all outputs to 0 and the state to IDLE. It also clears the fetch counter, byte index and all valid flags.
- FSM states:
  - IDLE: start=1 -> RUN, fetch_addr=0, pixel count cleared.
  - RUN: fetch and serve pixels; after the final transfer -> DONE.
  - DONE: pulse frame_done for one cycle -> IDLE.
- start is ignored outside IDLE.
- Buffering uses two word slots, cur and nxt, plus one in-flight read flag.
- occupancy = cur_valid + nxt_valid + inflight.
- Fetch rule: mem_rd = RUN && occupancy<2 && fetch_addr<WORD_COUNT. mem_address = fetch_addr. fetch_addr increments on each mem_rd.
- Returning data goes to cur if cur is empty or is being freed this cycle; otherwise it goes to nxt.
- Unpack order: byte index 0..3 maps to mem_data[7:0], [15:8], [23:16], [31:24].
- pixel = cur[8*idx+7 -: 8]. pixel_valid = cur_valid.
- Transfer occurs when pixel_valid && pixel_ready. On a transfer, idx increments.
- When the transfer consumes idx 3:
  - idx returns to 0.
  - cur loads nxt if nxt_valid; otherwise cur loads the returning word if one is in flight; otherwise cur_valid clears.
- Last pixel: the transfer of idx 3 of word WORD_COUNT-1 -> DONE.
- The frame ends cleanly: no reads are issued beyond WORD_COUNT-1, and the buffers are empty on entry to DONE.
- Backpressure: pixel and idx hold while pixel_ready=0. No further reads are issued once occupancy reaches 2.
- Reset mid-frame aborts immediately. An in-flight memory return is discarded because the valid flags are cleared.

## Timing
- start sampled at edge k:
  - busy=1 from k+1.
  - mem_rd=1 with address 0 during cycle k+1.
  - pixel_valid=1 with byte 0 of word 0 from k+3.
- With pixel_ready held at 1, throughput is 1 pixel/cycle with no bubbles at word boundaries. A full frame takes 4*WORD_COUNT transfer cycles.
- frame_done is high in the cycle after the final transfer. busy falls in that same cycle. A new start is accepted from the following cycle.
- All outputs except mem_rd and pixel are registered. mem_rd is combinational from registered state. pixel is a mux of registered state.

## Configuration
- CONTINUOUS_FRAME_EN defined: after the last word is fetched, fetch_addr wraps to 0 and fetching continues without a break. frame_done pulses at each frame end, but the FSM stays in RUN. Pixel flow continues with no gap, and start is needed only once. DONE is unused.
- CONTINUOUS_FRAME_EN undefined: single-frame behaviour as described above.

## Structure
- Shared package vga_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the WORD_COUNT default, pixel width (8) and pixels-per-word (4) constants, which are shared with the processor-side transfer block.
- One natural sub-module is word_unpacker: the cur/nxt slots, idx and handshake logic. It takes a word in and produces a pixel stream out. The top level keeps the FSM and fetch counter.

## Test plan
- Basic frame, WORD_COUNT=4:
  - Stimulus: memory word n = {4{8'hn0}} + {8'h3,8'h2,8'h1,8'h0}; pulse start; hold pixel_ready=1.
  - Required response: 16 pixels 00,01,02,03,10,...,33 on consecutive cycles from start+3; a frame_done pulse; exactly 4 mem_rd pulses at addresses 0..3.
- Backpressure:
  - Stimulus: pixel_ready toggling 1,0,0,1,...
  - Required response: no pixel lost or duplicated; pixel stable while ready=0; occupancy never >2; no read after address 3.
- Word-boundary stall:
  - Stimulus: pixel_ready=0 while idx=3 for 10 cycles.
  - Required response: mem_rd stays low after nxt fills; on release, the next byte is byte 0 of the following word.
- Reset mid-frame:
  - Stimulus: assert reset in the same cycle as a mem_rd.
  - Required response: all outputs 0 immediately. After release and a new start, the frame restarts at address 0 and the stale return is ignored.
- start during RUN:
  - Stimulus: pulse start in RUN.
  - Required response: no effect on addresses or pixel order.
- CONTINUOUS_FRAME_EN, WORD_COUNT=2:
  - Stimulus: one start; pixel_ready held at 1.
  - Required response: addresses 0,1,0,1,...; frame_done every 8 cycles; busy stays 1.
